// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants and types for the EX-stage multiply/divide sequencer.
//   - Default operand width and iteration counter width.
//   - Operation select encoding (OpMul / OpDiv).
//   - FSM state type; StFixup exists only when SIGNED_MULDIV_EN is defined.
package muldiv_pkg;

   localparam int unsigned DefWidth = 32;
   localparam int unsigned DefCntW  = 6;

   localparam logic OpMul = 1'b0;
   localparam logic OpDiv = 1'b1;

   typedef enum logic [2:0] {
      StIdle  = 3'd0,
      StMul   = 3'd1,
      StDiv   = 3'd2,
`ifdef SIGNED_MULDIV_EN
      StFixup = 3'd4,
`endif
      StDone  = 3'd3
   } state_e;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the multiply/divide sequencer.
//   op       in   operation select (OpMul / OpDiv)
//   acc      in   2*WIDTH working register
//                 multiply: {partial product upper half, remaining multiplier bits}
//                 divide:   {partial remainder, dividend bits / quotient bits}
//   opnd     in   multiplicand (multiply) or divisor (divide)
//   acc_next out  working register after this iteration
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth
) (
   input  logic                 op,
   input  logic [2*WIDTH-1:0]   acc,
   input  logic [WIDTH-1:0]     opnd,
   output logic [2*WIDTH-1:0]   acc_next
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shl;
   logic [WIDTH-1:0] diff;

   always_comb begin
      // Add-shift: WIDTH+1-bit add keeps the carry, which shifts into the top bit.
      sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      // The shifted remainder can need WIDTH+1 bits when the divisor exceeds 2**(WIDTH-1);
      // comparing at that width keeps large divisors correct. The difference always fits.
      shl  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      diff = shl[WIDTH-1:0] - opnd;
      if (op == OpMul) begin
         acc_next = {sum, acc[WIDTH-1:1]};
      end else if (shl >= {1'b0, opnd}) begin
         acc_next = {diff, acc[WIDTH-2:0], 1'b1};
      end else begin
         acc_next = {shl[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq: iterative unsigned multiply/divide sequencer beside the EX-stage ALU.
// Captures a/b on start, runs WIDTH shift-add or restoring-divide iterations, writes HI/LO.
//   clk, rst_n    clock, asynchronous active-low reset
//   start, op     begin MULTU (op=0) / DIVU (op=1); sampled only in idle
//   a, b          multiplicand/dividend, multiplier/divisor
//   kill          flush of the EX instruction; aborts the operation
//   stall         combinational pipeline freeze
//   busy, done    iterating; one-cycle pulse when hi/lo are updated
//   hi, lo        product upper/lower half, or remainder/quotient
//   div_by_zero   sticky until next accepted start
// Optional: SIGNED_MULDIV_EN adds input is_signed and a FIXUP state that applies result signs.
module ex_muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH = DefWidth,
   parameter int unsigned CNT_W = DefCntW
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             kill,
`ifdef SIGNED_MULDIV_EN
   input  logic             is_signed,
`endif
   output logic             stall,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             div_by_zero
);

   localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

   state_e             state_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [2*WIDTH-1:0] acc_next;
   logic [WIDTH-1:0]   opnd_q;
   logic               op_q;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;

`ifdef SIGNED_MULDIV_EN
   logic               sgn_q;
   logic               neg_q;
   logic               neg_rem_q;
   logic               a_neg;
   logic               b_neg;
   logic [2*WIDTH-1:0] fix_acc;

   assign a_neg = is_signed & a[WIDTH-1];
   assign b_neg = is_signed & b[WIDTH-1];
   assign a_mag = a_neg ? -a : a;
   assign b_mag = b_neg ? -b : b;

   always_comb begin
      if (op_q == OpMul) begin
         fix_acc = neg_q ? -acc_q : acc_q;
      end else begin
         fix_acc[2*WIDTH-1:WIDTH] = neg_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
         fix_acc[WIDTH-1:0]       = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      end
   end
`else
   assign a_mag = a;
   assign b_mag = b;
`endif

   muldiv_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .op       (op_q),
      .acc      (acc_q),
      .opnd     (opnd_q),
      .acc_next (acc_next)
   );

   // Zero in DONE so the instruction leaves EX while the result is committed.
   assign stall = busy | ((state_q == StIdle) & start & ~kill);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         acc_q       <= '0;
         opnd_q      <= '0;
         op_q        <= OpMul;
         hi          <= '0;
         lo          <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
`ifdef SIGNED_MULDIV_EN
         sgn_q       <= 1'b0;
         neg_q       <= 1'b0;
         neg_rem_q   <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         // A kill in DONE arrives after the commit and is ignored.
         if (kill && state_q != StDone) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy    <= 1'b0;
         end else begin
            case (state_q)
               StIdle: begin
                  if (start) begin
                     cnt_q       <= '0;
                     div_by_zero <= 1'b0;
                     op_q        <= op;
`ifdef SIGNED_MULDIV_EN
                     sgn_q       <= is_signed;
                     neg_q       <= a_neg ^ b_neg;
                     neg_rem_q   <= a_neg;
`endif
                     if (op == OpMul) begin
                        acc_q   <= {{WIDTH{1'b0}}, b_mag};
                        opnd_q  <= a_mag;
                        busy    <= 1'b1;
                        state_q <= StMul;
                     end else if (b != '0) begin
                        acc_q   <= {{WIDTH{1'b0}}, a_mag};
                        opnd_q  <= b_mag;
                        busy    <= 1'b1;
                        state_q <= StDiv;
                     end else begin
                        hi          <= a;
                        lo          <= '1;
                        div_by_zero <= 1'b1;
                        done        <= 1'b1;
                        state_q     <= StDone;
                     end
                  end
               end
               StMul, StDiv: begin
                  acc_q <= acc_next;
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == LastCnt) begin
`ifdef SIGNED_MULDIV_EN
                     // busy stays high through FIXUP so the pipeline waits for the signed result.
                     if (sgn_q) begin
                        state_q <= StFixup;
                     end else begin
                        hi      <= acc_next[2*WIDTH-1:WIDTH];
                        lo      <= acc_next[WIDTH-1:0];
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_q <= StDone;
                     end
`else
                     hi      <= acc_next[2*WIDTH-1:WIDTH];
                     lo      <= acc_next[WIDTH-1:0];
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     state_q <= StDone;
`endif
                  end
               end
`ifdef SIGNED_MULDIV_EN
               StFixup: begin
                  hi      <= fix_acc[2*WIDTH-1:WIDTH];
                  lo      <= fix_acc[WIDTH-1:0];
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_q <= StDone;
               end
`endif
               StDone:  state_q <= StIdle;
               default: state_q <= StIdle;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ex_muldiv_seq.sv
// tb_ex_muldiv_seq: directed bench for ex_muldiv_seq with a result scoreboard.
// Expected hi/lo/div_by_zero come from a reference model and are queued at start.
module tb_ex_muldiv_seq;

   typedef struct packed {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        op;
   logic [31:0] a;
   logic [31:0] b;
   logic        kill;
   logic        stall;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;
   logic        div_by_zero;

   int   n_checks = 0;
   int   n_pass   = 0;
   exp_t sb[$];
   exp_t got;
   int   nd;
   int   t1;
   int   t2;

   ex_muldiv_seq #(
      .WIDTH (32),
      .CNT_W (6)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .op          (op),
      .a           (a),
      .b           (b),
      .kill        (kill),
`ifdef SIGNED_MULDIV_EN
      .is_signed   (1'b0),
`endif
      .stall       (stall),
      .busy        (busy),
      .done        (done),
      .hi          (hi),
      .lo          (lo),
      .div_by_zero (div_by_zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before 200000");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   function automatic exp_t model(input logic o, input logic [31:0] x, input logic [31:0] y);
      exp_t        e;
      logic [63:0] p;
      if (o == 1'b0) begin
         p = {32'h0, x} * {32'h0, y};
         e = '{hi: p[63:32], lo: p[31:0], dbz: 1'b0};
      end else if (y == 32'h0) begin
         e = '{hi: x, lo: 32'hFFFF_FFFF, dbz: 1'b1};
      end else begin
         e = '{hi: x % y, lo: x / y, dbz: 1'b0};
      end
      return e;
   endfunction

   // Entered just after a rising edge (cycle 0); start held while stalled, as a frozen EX would.
   task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y,
                         input string tag);
      exp_t e;
      exp_t r;
      int   lat;
      int   n;
      int   st;
      bit   seen;
      e   = model(o, x, y);
      lat = (o == 1'b1 && y == 32'h0) ? 1 : 33;
      sb.push_back(e);
      start = 1'b1; op = o; a = x; b = y;
      n = 0; st = 0; seen = 0;
      while (!seen && n <= 60) begin
         @(negedge clk);
         if (n == 1) check({tag, "_dbz_c1"}, div_by_zero, e.dbz);
         if (done) begin
            seen = 1;
         end else begin
            if (stall) st++;
            @(posedge clk); #1;
            n++;
         end
      end
      check({tag, "_latency"}, n, lat);
      check({tag, "_stall_cycles"}, st, lat);
      check({tag, "_stall_done"}, stall, 1'b0);
      check({tag, "_busy_done"}, busy, 1'b0);
      r = sb.pop_front();
      check({tag, "_hi"}, hi, r.hi);
      check({tag, "_lo"}, lo, r.lo);
      check({tag, "_dbz"}, div_by_zero, r.dbz);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check({tag, "_done_pulse"}, done, 1'b0);
      @(posedge clk); #1;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; op = 1'b0; a = '0; b = '0; kill = 1'b0;
      #12;
      check("rst_hi", hi, 32'h0);
      check("rst_lo", lo, 32'h0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_dbz", div_by_zero, 1'b0);
      check("rst_stall", stall, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      run_op(1'b0, 32'd7, 32'd6, "mul_7x6");
      run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mul_max");
      run_op(1'b1, 32'd100, 32'd7, "div_100_7");
      run_op(1'b1, 32'h8000_0000, 32'd1, "div_msb_1");
      run_op(1'b1, 32'hFFFF_FFFF, 32'h8000_0001, "div_big_divisor");
      run_op(1'b1, 32'd5, 32'd0, "div_by_zero");
      run_op(1'b0, 32'd7, 32'd6, "mul_preload");

      // Kill at iteration 10 of DIV 100/7: no done, hi/lo keep 0/42.
      start = 1'b1; op = 1'b1; a = 32'd100; b = 32'd7;
      repeat (10) begin
         @(posedge clk); #1;
      end
      kill = 1'b1;
      @(posedge clk); #1;
      kill = 1'b0; start = 1'b0;
      @(negedge clk);
      check("kill_busy", busy, 1'b0);
      check("kill_stall", stall, 1'b0);
      nd = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done) nd++;
      end
      check("kill_no_done", nd, 0);
      check("kill_hi", hi, 32'h0);
      check("kill_lo", lo, 32'd42);
      check("kill_dbz", div_by_zero, 1'b0);

      // kill together with start in idle starts nothing.
      @(posedge clk); #1;
      start = 1'b1; kill = 1'b1; op = 1'b0; a = 32'd3; b = 32'd3;
      @(negedge clk);
      check("kill_start_stall", stall, 1'b0);
      @(posedge clk); #1;
      start = 1'b0; kill = 1'b0;
      @(negedge clk);
      check("kill_start_busy", busy, 1'b0);

      // Asynchronous reset mid-multiply.
      @(posedge clk); #1;
      start = 1'b1; op = 1'b0; a = 32'd7; b = 32'd6;
      repeat (10) begin
         @(posedge clk); #1;
      end
      check("pre_rst_busy", busy, 1'b1);
      start = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      check("arst_hi", hi, 32'h0);
      check("arst_lo", lo, 32'h0);
      check("arst_busy", busy, 1'b0);
      check("arst_done", done, 1'b0);
      check("arst_stall", stall, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Operand/start churn while busy, then a back-to-back MUL.
      sb.push_back(model(1'b0, 32'd3, 32'd5));
      sb.push_back(model(1'b0, 32'h1234_5678, 32'h10));
      start = 1'b1; op = 1'b0; a = 32'd3; b = 32'd5;
      nd = 0; t1 = -1; t2 = -1;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         if (done) begin
            if (nd == 0) t1 = c;
            else t2 = c;
            nd++;
            if (sb.size() > 0) begin
               got = sb.pop_front();
               check("b2b_hi", hi, got.hi);
               check("b2b_lo", lo, got.lo);
            end
         end
         @(posedge clk); #1;
         if (c + 1 <= 32) begin
            start = 1'($urandom_range(0, 1));
            op    = 1'($urandom_range(0, 1));
            a     = $urandom;
            b     = $urandom;
         end else if (c + 1 <= 34) begin
            start = 1'b1; op = 1'b0; a = 32'h1234_5678; b = 32'h10;
         end else begin
            start = 1'b0;
         end
      end
      check("b2b_done_count", nd, 2);
      check("b2b_first_done", t1, 33);
      check("b2b_spacing", t2 - t1, 34);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ex_muldiv_seq.md
Name: ex_muldiv_seq

Overview:
- Iterative unsigned multiply/divide sequencer in the EX stage, alongside the single-cycle ALU.
- Captures the EX operands (rdata1, rdata2) on start, runs WIDTH shift-add or restoring-divide iterations, and writes HI/LO.
- Holds the pipeline via stall until the result is ready.
- Provides the multi-cycle resource that MULTU/DIVU (and MFHI/MFLO consumers) need.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  EX holds a MULTU/DIVU; sampled only in IDLE.
- op  in  1  0 = multiply, 1 = divide.
- a  in  WIDTH  multiplicand / dividend (rdata1).
- b  in  WIDTH  multiplier / divisor (rdata2).
- kill  in  1  flush of the EX instruction; aborts the operation.
- stall  out  1  freezes IF/ID/EX, combinational.
- busy  out  1  in MUL or DIV state, registered.
- done  out  1  one-cycle pulse when HI/LO are updated.
- hi  out  WIDTH  HI register (product upper half / remainder).
- lo  out  WIDTH  LO register (product lower half / quotient).
- div_by_zero  out  1  sticky until next start; set by a divide with b==0.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, counter=0.
  - hi=0, lo=0, busy=0, done=0, div_by_zero=0; internal accumulators 0.
- States: IDLE, MUL, DIV, DONE.
- IDLE:
  - start=1 & kill=0: latch a/b, clear div_by_zero, counter=0.
  - op=0 -> MUL. op=1 & b!=0 -> DIV. op=1 & b==0 -> DONE.
- MUL, each cycle:
  - If multiplier LSB=1, add multiplicand into the upper half of the 2*WIDTH accumulator (WIDTH+1-bit add, carry kept).
  - Shift the accumulator right 1; counter++.
  - Counter reaches WIDTH-1 -> DONE.
- DIV, each cycle (restoring):
  - remainder = {remainder[WIDTH-2:0], dividend MSB}.
  - If remainder >= divisor: subtract and shift a 1 into the quotient; else shift in 0.
  - counter++; counter reaches WIDTH-1 -> DONE.
- Entry to DONE (registered on that edge):
  - MUL: {hi,lo} = a*b.
  - DIV: lo = quotient, hi = remainder.
  - Divide by zero: lo = all ones, hi = a, div_by_zero = 1.
- DONE: done=1 for exactly one cycle, then -> IDLE unconditionally. start is ignored in DONE.
- Latency: start at cycle 0 -> done and new hi/lo visible at cycle WIDTH+1 (33). Divide by zero: cycle 1.
- stall = busy | (state==IDLE & start & ~kill).
  - stall is 0 in DONE, so the instruction leaves EX in the DONE cycle.
  - The next instruction's start is seen in IDLE one cycle later. Back-to-back ops therefore cost WIDTH+2 cycles each.
- busy=1 exactly in MUL/DIV.
- kill:
  - In any state: next state IDLE, counter cleared, no done pulse.
  - hi/lo/div_by_zero keep their pre-start values.
  - kill in the DONE cycle is too late; the result is already committed.
- start while busy: ignored. Operands are held internally, so a/b changes mid-operation have no effect.
- Simultaneous kill & start in IDLE: no operation started, stall=0.
- Reset mid-operation: immediate return to reset values.

Optional Feature:
- SIGNED_MULDIV_EN defined:
  - Adds input is_signed (1 bit, sampled with start) for MULT/DIV.
  - Operands are converted to magnitudes at capture.
  - An extra FIXUP state after the last iteration negates the result per the sign rules. Product negated if signs differ. Quotient negated if signs differ. Remainder takes the dividend's sign.
  - Signed latency is WIDTH+2. Unsigned latency is unchanged.
- Not defined: no is_signed port, no FIXUP state; all operations unsigned.

Decomposition:
- Package muldiv_pkg:
  - State encoding constants IDLE/MUL/DIV/DONE (plus FIXUP).
  - OP_MUL=0, OP_DIV=1.
  - Default WIDTH/CNT_W constants.
- Sub-module muldiv_step: combinational single iteration (add-shift or compare-subtract-shift), selected by op. It is instantiated once; the FSM, counter and registers stay in ex_muldiv_seq.

Test Plan:
- MUL 7 x 6, start at cycle 0 -> stall high cycles 0-32, done at cycle 33, hi=0x00000000, lo=0x0000002A.
- MUL 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; carry path exercised.
- DIV 100 / 7 -> lo=14, hi=2, div_by_zero=0. Then DIV 0x80000000 / 1 -> lo=0x80000000, hi=0.
- DIV 5 / 0 -> done at cycle 1, lo=0xFFFFFFFF, hi=5, div_by_zero=1. The next valid start clears div_by_zero.
- Preload hi/lo with 42 via a MUL. Start DIV 100/7, pulse kill at iteration 10 -> IDLE next cycle, no done, hi/lo still 0/42.
- Repeat with rst_n low mid-MUL instead of kill -> all outputs 0 asynchronously.
- Toggle start and a/b during busy -> result unchanged; back-to-back MULs produce done pulses 34 cycles apart.
